// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the WISC-S25 pipeline hazard controller.
package hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        DRAIN    = 2'd2,
        HALTED   = 2'd3
    } ctrl_state_t;

    // Instruction word loaded into IF/ID on flush and into ID/EX on bubble.
    localparam logic [15:0] NOP_INSTR = 16'h0000;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard detector: a load in EX whose destination
// is read by the instruction in ID. Register 0 never creates a hazard.
module load_use_detect #(
    parameter int REG_ADDR_W = 4
) (
    input  logic                  mem_read,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  uses_rt,
    output logic                  load_use
);

    // Compare the load destination against each source the ID instruction reads.
    always_comb begin
        load_use = mem_read && (ex_rd != '0) &&
                   ((ex_rd == id_rs) || (uses_rt && (ex_rd == id_rt)));
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use stalls, taken
// branch flushes, cache-miss waits and HLT drain.
// Optional build macro HAZARD_STATS_EN adds saturating hazard counters.
module pipeline_hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W   = 4,
    parameter int DRAIN_CYCLES = 3,
    parameter int MISS_TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  id_ex_mem_read,
    input  logic [REG_ADDR_W-1:0] id_ex_rd,
    input  logic [REG_ADDR_W-1:0] if_id_rs,
    input  logic [REG_ADDR_W-1:0] if_id_rt,
    input  logic                  if_id_uses_rt,
    input  logic                  id_branch_taken,
    input  logic                  id_is_hlt,
    input  logic                  mem_miss,
    input  logic                  mem_ready,
    output logic                  pc_we,
    output logic                  if_id_we,
    output logic                  if_id_flush,
    output logic                  id_ex_bubble,
    output logic                  ex_mem_we,
    output logic                  mem_wb_we,
    output logic                  halted,
    output logic                  err,
`ifdef HAZARD_STATS_EN
    output logic [15:0]           stall_cycles,
    output logic [15:0]           flush_count,
    output logic [15:0]           miss_cycles,
`endif
    output logic [1:0]            ctrl_state
);

    localparam int MISS_W  = $clog2(MISS_TIMEOUT + 1);
    localparam int DRAIN_W = $clog2(DRAIN_CYCLES + 1);

    ctrl_state_t        state, next_state, ret_state;
    logic [DRAIN_W-1:0] drain_cnt;
    logic [MISS_W-1:0]  miss_cnt;
    logic               load_use;

    load_use_detect #(.REG_ADDR_W(REG_ADDR_W)) u_load_use (
        .mem_read (id_ex_mem_read),
        .ex_rd    (id_ex_rd),
        .id_rs    (if_id_rs),
        .id_rt    (if_id_rt),
        .uses_rt  (if_id_uses_rt),
        .load_use (load_use)
    );

    // State register plus the drain/miss counters, return state and sticky error.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= RUN;
            ret_state <= RUN;
            drain_cnt <= '0;
            miss_cnt  <= '0;
            err       <= 1'b0;
        end else begin
            state <= next_state;
            case (state)
                RUN: begin
                    if (mem_miss) begin
                        ret_state <= RUN;
                    end else if (!load_use && id_is_hlt) begin
                        drain_cnt <= '0;
                    end
                end
                MEM_WAIT: begin
                    if (mem_ready) begin
                        miss_cnt <= '0;
                    end else if (miss_cnt != MISS_W'(MISS_TIMEOUT)) begin
                        miss_cnt <= miss_cnt + 1'b1;
                        // Flag on the edge where the counter reaches the limit.
                        if (miss_cnt == MISS_W'(MISS_TIMEOUT - 1)) begin
                            err <= 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (mem_miss) begin
                        ret_state <= DRAIN;
                    end else if (drain_cnt != DRAIN_W'(DRAIN_CYCLES - 1)) begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Next-state selection; a miss beats every other hazard.
    always_comb begin
        next_state = state;
        case (state)
            RUN: begin
                if (mem_miss)                    next_state = MEM_WAIT;
                else if (!load_use && id_is_hlt) next_state = DRAIN;
            end
            MEM_WAIT: begin
                if (mem_ready) next_state = ret_state;
            end
            DRAIN: begin
                if (mem_miss)                                    next_state = MEM_WAIT;
                else if (drain_cnt == DRAIN_W'(DRAIN_CYCLES - 1)) next_state = HALTED;
            end
            default: next_state = HALTED;
        endcase
    end

    // Enables, flush and bubble decoded from state and the same-cycle hazards.
    always_comb begin
        pc_we        = 1'b1;
        if_id_we     = 1'b1;
        ex_mem_we    = 1'b1;
        mem_wb_we    = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        halted       = 1'b0;
        case (state)
            RUN: begin
                if (mem_miss) begin
                    pc_we     = 1'b0;
                    if_id_we  = 1'b0;
                    ex_mem_we = 1'b0;
                    mem_wb_we = 1'b0;
                end else if (load_use) begin
                    // Stalling takes precedence over a branch flush; the branch
                    // re-resolves once the load result is available.
                    pc_we        = 1'b0;
                    if_id_we     = 1'b0;
                    id_ex_bubble = 1'b1;
                end else if (id_is_hlt) begin
                    pc_we    = 1'b0;
                    if_id_we = 1'b0;
                end else if (id_branch_taken) begin
                    if_id_flush = 1'b1;
                end
            end
            MEM_WAIT: begin
                pc_we     = 1'b0;
                if_id_we  = 1'b0;
                ex_mem_we = 1'b0;
                mem_wb_we = 1'b0;
            end
            DRAIN: begin
                pc_we    = 1'b0;
                if_id_we = 1'b0;
                if (mem_miss) begin
                    ex_mem_we = 1'b0;
                    mem_wb_we = 1'b0;
                end else begin
                    id_ex_bubble = 1'b1;
                end
            end
            default: begin
                pc_we     = 1'b0;
                if_id_we  = 1'b0;
                ex_mem_we = 1'b0;
                mem_wb_we = 1'b0;
                halted    = 1'b1;
            end
        endcase
    end

    assign ctrl_state = state;

`ifdef HAZARD_STATS_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Saturating hazard statistics, cleared by reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cycles <= '0;
            flush_count  <= '0;
            miss_cycles  <= '0;
        end else begin
            if (state == RUN && !pc_we) stall_cycles <= sat_inc(stall_cycles);
            if (if_id_flush)            flush_count  <= sat_inc(flush_count);
            if (state == MEM_WAIT)      miss_cycles  <= sat_inc(miss_cycles);
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl.
module tb_pipeline_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       id_ex_mem_read;
    logic [3:0] id_ex_rd;
    logic [3:0] if_id_rs;
    logic [3:0] if_id_rt;
    logic       if_id_uses_rt;
    logic       id_branch_taken;
    logic       id_is_hlt;
    logic       mem_miss;
    logic       mem_ready;
    logic       pc_we, if_id_we, if_id_flush, id_ex_bubble;
    logic       ex_mem_we, mem_wb_we, halted, err;
    logic [1:0] ctrl_state;
`ifdef HAZARD_STATS_EN
    logic [15:0] stall_cycles, flush_count, miss_cycles;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .id_ex_mem_read  (id_ex_mem_read),
        .id_ex_rd        (id_ex_rd),
        .if_id_rs        (if_id_rs),
        .if_id_rt        (if_id_rt),
        .if_id_uses_rt   (if_id_uses_rt),
        .id_branch_taken (id_branch_taken),
        .id_is_hlt       (id_is_hlt),
        .mem_miss        (mem_miss),
        .mem_ready       (mem_ready),
        .pc_we           (pc_we),
        .if_id_we        (if_id_we),
        .if_id_flush     (if_id_flush),
        .id_ex_bubble    (id_ex_bubble),
        .ex_mem_we       (ex_mem_we),
        .mem_wb_we       (mem_wb_we),
        .halted          (halted),
        .err             (err),
`ifdef HAZARD_STATS_EN
        .stall_cycles    (stall_cycles),
        .flush_count     (flush_count),
        .miss_cycles     (miss_cycles),
`endif
        .ctrl_state      (ctrl_state)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_en(input string tag, input logic pc, input logic ifid,
                            input logic exmem, input logic memwb);
        check({tag, "_pc_we"},     32'(pc_we),     32'(pc));
        check({tag, "_if_id_we"},  32'(if_id_we),  32'(ifid));
        check({tag, "_ex_mem_we"}, 32'(ex_mem_we), 32'(exmem));
        check({tag, "_mem_wb_we"}, 32'(mem_wb_we), 32'(memwb));
    endtask

    task automatic clear_in();
        id_ex_mem_read  = 1'b0;
        id_ex_rd        = 4'd0;
        if_id_rs        = 4'd0;
        if_id_rt        = 4'd0;
        if_id_uses_rt   = 1'b0;
        id_branch_taken = 1'b0;
        id_is_hlt       = 1'b0;
        mem_miss        = 1'b0;
        mem_ready       = 1'b0;
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench timed out");
    end

    initial begin
        rst_n = 1'b0;
        clear_in();
        next();
        next();
        #1;
        check_en("rst", 1, 1, 1, 1);
        check("rst_flush",  32'(if_id_flush),  0);
        check("rst_bubble", 32'(id_ex_bubble), 0);
        check("rst_halted", 32'(halted),       0);
        check("rst_err",    32'(err),          0);
        check("rst_state",  32'(ctrl_state),   0);
        rst_n = 1'b1;
        next();

        // Load-use on rs: stall this cycle, resume next cycle.
        id_ex_mem_read = 1'b1; id_ex_rd = 4'd3; if_id_rs = 4'd3;
        #1;
        check_en("lu_rs", 0, 0, 1, 1);
        check("lu_rs_bubble", 32'(id_ex_bubble), 1);
        next();
        clear_in();
        #1;
        check_en("lu_clear", 1, 1, 1, 1);
        check("lu_clear_bubble", 32'(id_ex_bubble), 0);

        // Load-use on rt with uses_rt set.
        id_ex_mem_read = 1'b1; id_ex_rd = 4'd7; if_id_rs = 4'd2; if_id_rt = 4'd7; if_id_uses_rt = 1'b1;
        #1;
        check("lu_rt_pc_we",  32'(pc_we),        0);
        check("lu_rt_bubble", 32'(id_ex_bubble), 1);

        // Register 0 never hazards; rt match ignored without uses_rt.
        next();
        clear_in();
        id_ex_mem_read = 1'b1; id_ex_rd = 4'd0; if_id_rs = 4'd0;
        #1;
        check("r0_pc_we",  32'(pc_we),        1);
        check("r0_bubble", 32'(id_ex_bubble), 0);
        id_ex_rd = 4'd5; if_id_rs = 4'd1; if_id_rt = 4'd5; if_id_uses_rt = 1'b0;
        #1;
        check("nort_pc_we",  32'(pc_we),        1);
        check("nort_bubble", 32'(id_ex_bubble), 0);

        // Taken branch alone flushes; with load-use the flush is suppressed.
        next();
        clear_in();
        id_branch_taken = 1'b1;
        #1;
        check("br_flush", 32'(if_id_flush), 1);
        check("br_pc_we", 32'(pc_we),       1);
        id_ex_mem_read = 1'b1; id_ex_rd = 4'd4; if_id_rs = 4'd4;
        #1;
        check("br_lu_flush",  32'(if_id_flush),  0);
        check("br_lu_bubble", 32'(id_ex_bubble), 1);
        check("br_lu_pc_we",  32'(pc_we),        0);

        // Cache miss: enables low from the miss cycle through the ready cycle.
        next();
        clear_in();
        mem_miss = 1'b1;
        #1;
        check_en("miss0", 0, 0, 0, 0);
        check("miss0_bubble", 32'(id_ex_bubble), 0);
        check("miss0_state",  32'(ctrl_state),   0);
        for (int i = 0; i < 3; i++) begin
            next();
            mem_miss = (i == 1);
            #1;
            check("miss_wait_state", 32'(ctrl_state), 1);
            check_en("miss_wait", 0, 0, 0, 0);
        end
        next();
        mem_miss  = 1'b0;
        mem_ready = 1'b1;
        #1;
        check("miss_ready_state", 32'(ctrl_state), 1);
        check_en("miss_ready", 0, 0, 0, 0);
        next();
        mem_ready = 1'b0;
        #1;
        check("miss_resume_state", 32'(ctrl_state), 0);
        check_en("miss_resume", 1, 1, 1, 1);

        // HLT drain with a miss during the second drain cycle.
        id_is_hlt = 1'b1;
        #1;
        check_en("hlt0", 0, 0, 1, 1);
        check("hlt0_state", 32'(ctrl_state), 0);
        next();
        id_is_hlt = 1'b0;
        #1;
        check("drain0_state",  32'(ctrl_state),   2);
        check("drain0_bubble", 32'(id_ex_bubble), 1);
        check_en("drain0", 0, 0, 1, 1);
        next();
        mem_miss = 1'b1;
        #1;
        check("drain1_miss_state", 32'(ctrl_state), 2);
        check_en("drain1_miss", 0, 0, 0, 0);
        next();
        mem_miss = 1'b0;
        #1;
        check("drain_wait_state", 32'(ctrl_state), 1);
        next();
        mem_ready = 1'b1;
        #1;
        check("drain_ready_state", 32'(ctrl_state), 1);
        next();
        mem_ready = 1'b0;
        #1;
        check("drain1_again_state", 32'(ctrl_state), 2);
        check("drain1_again_halted", 32'(halted), 0);
        next();
        #1;
        check("drain2_state", 32'(ctrl_state), 2);
        next();
        #1;
        check("halt_state",  32'(ctrl_state), 3);
        check("halt_halted", 32'(halted),     1);
        check_en("halt", 0, 0, 0, 0);
        mem_miss = 1'b1; id_branch_taken = 1'b1;
        next();
        clear_in();
        #1;
        check("halt_sticky_state", 32'(ctrl_state), 3);
        check("halt_sticky_flush", 32'(if_id_flush), 0);

        // Reset from HALTED, then a miss that never completes.
        rst_n = 1'b0;
        next();
        rst_n = 1'b1;
        #1;
        check("rst2_state",  32'(ctrl_state), 0);
        check("rst2_halted", 32'(halted),     0);
        mem_miss = 1'b1;
        next();
        mem_miss = 1'b0;
        repeat (253) next();
        #1;
        check("to_254_err",   32'(err),        0);
        check("to_254_state", 32'(ctrl_state), 1);
        next();
        next();
        #1;
        check("to_256_err",   32'(err),        1);
        check("to_256_state", 32'(ctrl_state), 1);
        repeat (10) next();
        #1;
        check("to_hold_err", 32'(err), 1);
        mem_ready = 1'b1;
        next();
        mem_ready = 1'b0;
        #1;
        check("to_resume_state", 32'(ctrl_state), 0);
        check("to_resume_err",   32'(err),        1);
        rst_n = 1'b0;
        next();
        #1;
        check("rst3_err",   32'(err),        0);
        check("rst3_state", 32'(ctrl_state), 0);
        rst_n = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage WISC-S25 pipeline (IF, ID, EX, MEM, WB).
- Arbitrates between four hazard sources: load-use hazards, taken branches resolved in ID, cache-miss waits and HLT drain.
- Drives the PC and pipeline-register write enables, the IF/ID flush and the ID/EX bubble.
- Its stall and flush outputs feed the pipeline registers and the verification unit's stall/flush inputs.

Parameters:
REG_ADDR_W, 4, register-specifier width.
DRAIN_CYCLES, 3, cycles needed for HLT to leave ID and retire (EX, MEM, WB).
MISS_TIMEOUT, 255, maximum MEM_WAIT cycles before err is raised (width: clog2(MISS_TIMEOUT+1)).

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous, active-low reset
id_ex_mem_read  in  1  instruction in EX is a load
id_ex_rd  in  REG_ADDR_W  destination of instruction in EX
if_id_rs  in  REG_ADDR_W  source 1 of instruction in ID
if_id_rt  in  REG_ADDR_W  source 2 of instruction in ID
if_id_uses_rt  in  1  ID instruction reads rt
id_branch_taken  in  1  branch/jump in ID resolved taken
id_is_hlt  in  1  ID instruction is HLT
mem_miss  in  1  one-cycle pulse: I- or D-cache miss started
mem_ready  in  1  one-cycle pulse: miss serviced
pc_we  out  1  PC write enable
if_id_we  out  1  IF/ID register write enable
if_id_flush  out  1  IF/ID register cleared to NOP
id_ex_bubble  out  1  ID/EX register loads NOP
ex_mem_we  out  1  EX/MEM register write enable
mem_wb_we  out  1  MEM/WB register write enable
halted  out  1  pipeline fully drained after HLT
err  out  1  sticky miss-timeout flag
ctrl_state  out  2  current FSM state (debug)

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rst_n.
- Reset values:
  - state = RUN, drain_cnt = 0, miss_cnt = 0, ret_state = RUN, err = 0.
  - Outputs during and after reset: all write enables = 1, if_id_flush = 0, id_ex_bubble = 0, halted = 0.
- Output timing: state is registered. All outputs except err are combinational from state and current inputs, so a hazard takes effect in the same cycle it is detected.
- load_use = id_ex_mem_read & (id_ex_rd != 0) & ((id_ex_rd == if_id_rs) | (if_id_uses_rt & (id_ex_rd == if_id_rt))). Register 0 never hazards.
- RUN state, priority highest first:
  1. mem_miss: all enables = 0, no bubble, no flush. ret_state <= RUN. Next state MEM_WAIT.
  2. load_use: pc_we = 0, if_id_we = 0, id_ex_bubble = 1, ex_mem_we = mem_wb_we = 1. Stay in RUN; the hazard clears next cycle.
  3. id_is_hlt: pc_we = 0, if_id_we = 0. HLT advances into EX. drain_cnt <= 0. Next state DRAIN.
  4. id_branch_taken: pc_we = 1 (target loads), if_id_flush = 1.
  5. Otherwise: all enables = 1, no flush, no bubble.
- A load_use coinciding with id_branch_taken suppresses the flush; the branch re-resolves next cycle.
- MEM_WAIT state:
  - All enables = 0; miss_cnt increments each cycle.
  - mem_ready: next state = ret_state, miss_cnt <= 0. Enables stay 0 in that cycle; the pipeline resumes the following cycle.
  - miss_cnt reaching MISS_TIMEOUT sets err (sticky until reset). The FSM remains in MEM_WAIT.
  - mem_miss while already in MEM_WAIT is ignored.
- DRAIN state:
  - pc_we = 0, if_id_we = 0, id_ex_bubble = 1, ex_mem_we = mem_wb_we = 1. drain_cnt increments.
  - mem_miss: enables = 0, drain_cnt holds, ret_state <= DRAIN, next state MEM_WAIT.
  - When drain_cnt == DRAIN_CYCLES-1 (and no miss): next state HALTED.
- HALTED state: all enables = 0, halted = 1. Only reset exits. Inputs are ignored.
- Reset mid-miss or mid-drain: returns to RUN with counters cleared. The cache controller must also be reset.

Optional Feature:
- Macro: HAZARD_STATS_EN.
- When defined, adds three outputs: stall_cycles[15:0], flush_count[15:0] and miss_cycles[15:0].
  - stall_cycles counts cycles with pc_we = 0 while in RUN.
  - flush_count counts cycles with if_id_flush = 1.
  - miss_cycles counts cycles spent in MEM_WAIT.
  - All three are saturating at 16'hFFFF and cleared by reset.
- When undefined, the ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Package hazard_ctrl_pkg holds ctrl_state_t (RUN = 2'd0, MEM_WAIT = 2'd1, DRAIN = 2'd2, HALTED = 2'd3) and the NOP encoding constant.
- One combinational sub-module, load_use_detect, computes load_use. It has no state.

Test Plan:
1. id_ex_mem_read = 1, id_ex_rd = 3, if_id_rs = 3 -> same cycle pc_we = 0, if_id_we = 0, id_ex_bubble = 1. Next cycle (read dropped) -> all enables = 1.
2. id_ex_rd = 0 with if_id_rs = 0 and load -> no stall. The same load with if_id_rt = 5 match but if_id_uses_rt = 0 -> no stall.
3. id_branch_taken = 1 alone -> if_id_flush = 1, pc_we = 1. The same cycle with load_use -> flush = 0, bubble = 1.
4. mem_miss pulse at cycle 10, mem_ready at cycle 14 -> enables = 0 for cycles 10-14, ctrl_state = 1 for cycles 11-14, RUN at cycle 15.
5. id_is_hlt at cycle 20 -> DRAIN for cycles 21-23, halted = 1 from cycle 24. A mem_miss at cycle 22 holds drain_cnt and returns to DRAIN after mem_ready.
6. mem_miss with no mem_ready for 255 cycles -> err = 1 and stays 1. rst_n = 0 for one edge -> err = 0, state RUN.
